// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage definitions: occupancy states and the count width.
// Every pipeline stage block imports this package.
package pipe_skid_stage_pkg;

  localparam int COUNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stageState_e;

  function automatic logic [COUNT_W-1:0] stateCount(input stageState_e s);
    case (s)
      EMPTY:   stateCount = 2'd0;
      BUSY:    stateCount = 2'd1;
      FULL:    stateCount = 2'd2;
      default: stateCount = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: a main register plus an optional skid register.
// With SKID=0 it degrades to a single stall/flush register with combinational in_ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
);

  stageState_e      state;
  stageState_e      nextState;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic             inXfer;
  logic             outXfer;

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= nextState;
  end

  // Flush wins over any handshake: a simultaneous input is dropped.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: if (inXfer) nextState = BUSY;
        BUSY: begin
          if (inXfer && !outXfer)      nextState = (SKID != 0) ? FULL : BUSY;
          else if (!inXfer && outXfer) nextState = EMPTY;
        end
        FULL: if (outXfer) nextState = BUSY;
        default: nextState = EMPTY;
      endcase
    end
  end

  // With SKID=1, in_ready depends only on registered state, never on out_ready.
  always_comb begin
    out_valid = (state != EMPTY);
    count     = stateCount(state);
    out_data  = mainData;
    if (SKID != 0) in_ready = (state != FULL) && !rst;
    else           in_ready = (!out_valid || out_ready) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainData <= '0;
      skidData <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH != 0) begin
        mainData <= '0;
        skidData <= '0;
      end
    end else begin
      case (state)
        EMPTY: if (inXfer) mainData <= in_data;
        BUSY: begin
          if (inXfer && outXfer)            mainData <= in_data;
          else if (inXfer && (SKID != 0))   skidData <= in_data;
        end
        FULL: if (outXfer) mainData <= skidData;
        default: ;
      endcase
    end
  end

endmodule
